// File: rtl/ssd_scan_controller_if.sv
// Bus between the display/output register (master) and the seven-segment
// scan controller (slave).
//
// Handshake: a transfer happens on a rising clk edge where load_valid and
// load_ready are both 1. The master holds load_valid and load_data steady
// until that edge. load_ready does not depend on load_valid.
interface ssd_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic                      blank;
    logic [3:0]                out_bcd;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      frame_tick;

    modport master (
        output load_valid, load_data, blank,
        input  load_ready, out_bcd, digit_en, frame_tick
    );

    modport slave (
        input  load_valid, load_data, blank,
        output load_ready, out_bcd, digit_en, frame_tick
    );
endinterface

// File: rtl/ssd_scan_controller.sv
// Seven-segment scan controller: time-multiplexes NUM_DIGITS BCD digits onto
// one shared decoder, with all-off gap cycles between digits. New values are
// staged in pend_q and only copied into disp_q when the scan wraps to digit 0
// (or at once while blanked), so a frame never mixes old and new digits.
// out_bcd and digit_en are registered from the next-state values, so data and
// enable always change on the same edge.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 always shows).
module ssd_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ssd_scan_controller_if.slave   bus,
    output logic [1:0]             dbg_state
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BW = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        S_SCAN  = 2'd0,
        S_GAP   = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         dig_idx_q, dig_idx_d;
    logic [DW-1:0]         div_cnt_q, div_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [BW-1:0]         disp_q, disp_d;
    logic [BW-1:0]         pend_q, pend_d;
    logic                  pending_q, pending_d;
    logic [3:0]            out_bcd_q, out_bcd_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  advance;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            cur_digit;

    // Next-state: handshake, scan sequencing, blanking and frame commit.
    always_comb begin
        state_d      = state_q;
        dig_idx_d    = dig_idx_q;
        div_cnt_d    = div_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pending_d    = pending_q;
        frame_tick_d = 1'b0;
        advance      = 1'b0;

        // Accept only while nothing is staged, so accept and commit never meet.
        if (bus.load_valid && !pending_q) begin
            pend_d    = bus.load_data;
            pending_d = 1'b1;
        end

        if (bus.blank) begin
            state_d   = S_BLANK;
            dig_idx_d = '0;
            div_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                S_SCAN: begin
                    if (div_cnt_q == DW'(REFRESH_DIV - 1)) begin
                        div_cnt_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        state_d = S_SCAN;
                        advance = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                S_BLANK: begin
                    state_d   = S_SCAN;
                    dig_idx_d = '0;
                    div_cnt_d = '0;
                end
                default: begin
                    state_d = S_BLANK;
                end
            endcase
        end

        // Digit advance; the wrap to digit 0 is the frame boundary.
        if (advance) begin
            if (dig_idx_q == IW'(NUM_DIGITS - 1)) begin
                dig_idx_d    = '0;
                frame_tick_d = 1'b1;
                if (pending_q) begin
                    disp_d    = pend_q;
                    pending_d = 1'b0;
                end
            end else begin
                dig_idx_d = dig_idx_q + 1'b1;
            end
        end

        // Nothing is lit while blanked, so a staged value can commit at once.
        if (state_q == S_BLANK && pending_q) begin
            disp_d    = pend_q;
            pending_d = 1'b0;
        end
    end

    // Output decode from next-state values so the registered outputs line up with state_q.
    always_comb begin
        lz_mask   = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lz_run;
            lz_run = 1'b1;
            for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
                lz_run     = lz_run && (disp_d[4*d +: 4] == 4'h0);
                lz_mask[d] = lz_run;
            end
        end
`endif
        cur_digit = disp_d[{dig_idx_d, 2'b00} +: 4];
        if (state_d == S_SCAN) begin
            out_bcd_d  = lz_mask[dig_idx_d] ? 4'hF : cur_digit;
            digit_en_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig_idx_d);
        end else begin
            out_bcd_d  = 4'hF;
            digit_en_d = '1;
        end
    end

    // State and output registers; reset picks the start state from blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= bus.blank ? S_BLANK : S_SCAN;
            dig_idx_q    <= '0;
            div_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pending_q    <= 1'b0;
            out_bcd_q    <= 4'hF;
            digit_en_q   <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dig_idx_q    <= dig_idx_d;
            div_cnt_q    <= div_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            out_bcd_q    <= out_bcd_d;
            digit_en_q   <= digit_en_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.load_ready = ~pending_q;
    assign bus.out_bcd    = out_bcd_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.frame_tick = frame_tick_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with NUM_DIGITS=4, REFRESH_DIV=4,
// GAP_CYCLES=1 (a frame is 20 cycles: 4 lit + 1 gap per digit).
// Outputs are sampled on the falling clock edge.
module tb_ssd_scan_controller;
  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  int checks;
  int failures;
  bit m_pending;
  bit drop_valid;

  ssd_scan_controller_if #(.NUM_DIGITS(4)) bus ();

  ssd_scan_controller #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .GAP_CYCLES (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected decoder input for digit d of value v.
  function automatic logic [3:0] exp_digit(input logic [15:0] v, input int d);
    logic [15:0] hi;
    hi = v >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && hi == 16'h0) return 4'hF;
`endif
    return hi[3:0];
  endfunction

  // Wait (bounded) for a frame_tick; returns at the falling edge where it is high.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) seen = 1'b1;
    end
    chk("frame_tick_seen", 16'(seen), 16'h1);
  endtask

  // Check one full frame starting at its first cycle, optionally offering loads.
  // A load offered at cycle inj is held until the handshake model accepts it.
  task automatic run_frame(input logic [15:0] val,
                           input int inj1, input logic [15:0] d1,
                           input int inj2, input logic [15:0] d2);
    bit p;
    int d;
    int pos;
    logic [3:0] e_en;
    logic [3:0] e_bcd;
    for (int i = 0; i < 20; i++) begin
      d = i / 5;
      pos = i % 5;
      if (pos < 4) begin
        e_en = ~(4'b0001 << d);
        e_bcd = exp_digit(val, d);
      end else begin
        e_en = 4'b1111;
        e_bcd = 4'hF;
      end
      p = m_pending;
      chk($sformatf("frame_%h_c%0d_en", val, i), 16'(bus.digit_en), 16'(e_en));
      chk($sformatf("frame_%h_c%0d_bcd", val, i), 16'(bus.out_bcd), 16'(e_bcd));
      chk($sformatf("frame_%h_c%0d_tick", val, i), 16'(bus.frame_tick), 16'(i == 0));
      chk($sformatf("frame_%h_c%0d_ready", val, i), 16'(bus.load_ready), 16'(!p));
      if (drop_valid) begin
        bus.load_valid = 1'b0;
        drop_valid = 1'b0;
      end
      if (i == inj1) begin
        bus.load_valid = 1'b1;
        bus.load_data = d1;
      end
      if (i == inj2) begin
        bus.load_valid = 1'b1;
        bus.load_data = d2;
      end
      if (i == 19 && p) begin
        m_pending = 1'b0;
      end else if (bus.load_valid && !p) begin
        m_pending = 1'b1;
        drop_valid = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_pending = 1'b0;
    drop_valid = 1'b0;
    rst_n = 1'b0;
    bus.blank = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = 16'h0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_bcd", 16'(bus.out_bcd), 16'hF);
    chk("rst_digit_en", 16'(bus.digit_en), 16'hF);
    chk("rst_load_ready", 16'(bus.load_ready), 16'h1);
    chk("rst_frame_tick", 16'(bus.frame_tick), 16'h0);

    // Load 0x1234; it commits at the first wrap
    rst_n = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 16'h1234;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("first_load_pending", 16'(bus.load_ready), 16'h0);
    chk("first_digit0_raw0", 16'(bus.out_bcd), 16'(exp_digit(16'h0, 0)));
    m_pending = 1'b1;
    wait_tick();
    m_pending = 1'b0;
    run_frame(16'h1234, -1, 16'h0, -1, 16'h0);

    // Load 0x5678 while digit 1 is lit, then a second value while pending
    run_frame(16'h1234, 5, 16'h5678, 10, 16'hABCD);
    run_frame(16'h5678, -1, 16'h0, -1, 16'h0);
    run_frame(16'hABCD, -1, 16'h0, -1, 16'h0);

    // Blank in the middle of digit 2, with a load committed while blanked
    repeat (11) @(negedge clk);
    chk("pre_blank_en", 16'(bus.digit_en), 16'hB);
    chk("pre_blank_bcd", 16'(bus.out_bcd), 16'hB);
    bus.blank = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 16'h9999;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("blank_en", 16'(bus.digit_en), 16'hF);
    chk("blank_bcd", 16'(bus.out_bcd), 16'hF);
    chk("blank_pending", 16'(bus.load_ready), 16'h0);
    @(negedge clk);
    chk("blank_commit_ready", 16'(bus.load_ready), 16'h1);
    chk("blank_en_hold", 16'(bus.digit_en), 16'hF);
    bus.blank = 1'b0;
    @(negedge clk);
    chk("unblank_tick", 16'(bus.frame_tick), 16'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("unblank_d0_en_%0d", k), 16'(bus.digit_en), 16'hE);
      chk($sformatf("unblank_d0_bcd_%0d", k), 16'(bus.out_bcd), 16'h9);
    end

    // Reset asserted mid-gap discards the pending value and the display
    bus.load_valid = 1'b1;
    bus.load_data = 16'h7777;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("gap_en", 16'(bus.digit_en), 16'hF);
    chk("gap_bcd", 16'(bus.out_bcd), 16'hF);
    chk("gap_pending", 16'(bus.load_ready), 16'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 16'(bus.load_ready), 16'h1);
    chk("async_rst_en", 16'(bus.digit_en), 16'hF);
    chk("async_rst_bcd", 16'(bus.out_bcd), 16'hF);
    @(negedge clk);
    rst_n = 1'b1;
    m_pending = 1'b0;
    @(negedge clk);
    chk("post_rst_en", 16'(bus.digit_en), 16'hE);
    chk("post_rst_bcd", 16'(bus.out_bcd), 16'h0);
    wait_tick();

    // Leading-zero handling: 0x0000 frame, then 0x0040
    run_frame(16'h0000, 2, 16'h0040, -1, 16'h0);
    run_frame(16'h0040, -1, 16'h0, -1, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
